hssi_tg_pkt_sched: RTL and testbench
====================================

HSSI_TG_PKT_SCHED -- requirements
Module: hssi_tg_pkt_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the packet-count, sequence and status counters.
REQ-002 SHALL have parameter LEN_W, default 16, width of the packet-length fields.
REQ-003 SHALL have parameter MIN_LEN, default 64, minimum packet length in bytes.
REQ-004 SHALL have parameter MAX_OUT, default 8, maximum number of issued packets without a completion (power of 2).
REQ-005 SHALL have a single clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: pulse that begins a run.
REQ-007 SHALL have port abort, input, 1 bit: level or pulse that stops issuing new packets.
REQ-008 SHALL have port num_pkt, input, CNT_W bits: packets per run.
REQ-009 SHALL have port len_type, input, 1 bit: 0 = fixed length, 1 = random length.
REQ-010 SHALL have port data_pattern, input, 1 bit: 0 = incremental pattern, 1 = random pattern.
REQ-011 SHALL have port pkt_len, input, LEN_W bits: fixed packet length.
REQ-012 SHALL have the descriptor ports desc_valid (output, 1), desc_ready (input, 1), desc_len (output, LEN_W), desc_pattern (output, 1) and desc_seq (output, CNT_W).
REQ-013 SHALL have port pkt_done, input, 1 bit: one-cycle completion pulse from the packet generator.
REQ-014 SHALL have status outputs busy (1), done (1), aborted (1), cpl_err (1), sent_cnt (CNT_W) and cpl_cnt (CNT_W).

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-016 SHALL accept start only in IDLE or DONE and ignore it in ISSUE and DRAIN.
REQ-017 On accepted start, SHALL latch num_pkt, len_type, data_pattern and pkt_len, clear sent_cnt, cpl_cnt, aborted and cpl_err, and reload the LFSR with seed 16'hACE1.
REQ-018 On accepted start with num_pkt != 0, SHALL enter ISSUE next cycle; with num_pkt == 0 it SHALL enter DONE directly.
REQ-019 SHALL assert desc_valid in ISSUE when outstanding < MAX_OUT, where outstanding = sent_cnt - cpl_cnt; the first desc_valid SHALL appear 1 cycle after start.
REQ-020 Once desc_valid is asserted, desc_valid, desc_len, desc_pattern and desc_seq SHALL hold stable until desc_ready is sampled high.
REQ-021 A handshake (desc_valid && desc_ready) SHALL increment sent_cnt and advance the LFSR one step; one descriptor per cycle SHALL be sustainable.
REQ-022 desc_seq SHALL equal sent_cnt at issue (0 for the first packet) and desc_pattern SHALL equal the latched data_pattern.
REQ-023 For fixed length, desc_len SHALL be max(pkt_len, MIN_LEN).
REQ-024 For random length, desc_len SHALL be MIN_LEN + lfsr[10:0], giving a range of 64..2111.
REQ-025 The LFSR SHALL be 16-bit Fibonacci with taps 16,14,13,11, shifting left with feedback into bit 0.
REQ-026 When the handshake making sent_cnt == latched num_pkt occurs, the FSM SHALL go to DRAIN next cycle.
REQ-027 A pkt_done with outstanding > 0 SHALL increment cpl_cnt.
REQ-028 A pkt_done with outstanding == 0 SHALL be ignored and SHALL set sticky cpl_err.
REQ-029 A handshake and a pkt_done in the same cycle SHALL update both counters, leaving outstanding unchanged.
REQ-030 In ISSUE, abort SHALL take effect when desc_valid is low or on the current handshake, then go to DRAIN with aborted=1; a pending descriptor SHALL never be withdrawn.
REQ-031 The FSM SHALL leave DRAIN for DONE in the cycle after outstanding reaches 0.
REQ-032 busy SHALL be 1 in ISSUE and DRAIN; done SHALL be 1 in DONE only.
REQ-033 Counters SHALL saturate at all-ones; sent_cnt SHALL never exceed latched num_pkt.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, LFSR=16'hACE1 and all outputs 0.
REQ-035 Reset mid-run SHALL discard the run; after release, no descriptor SHALL issue until a new start.

Verification
REQ-036 num_pkt=32'h20, len_type=0, pkt_len=16'h42, desc_ready=1, pkt_done 4 cycles after each issue -> 32 descriptors, desc_len=66, desc_seq 0..31, done=1, sent_cnt=cpl_cnt=32.
REQ-037 len_type=1, num_pkt=4 -> first desc_len=1313 (64+0x4E1); later lengths match the LFSR reference model and lie within 64..2111.
REQ-038 num_pkt=20, desc_ready=1, no pkt_done -> exactly 8 descriptors, desc_valid then low; one pkt_done -> exactly one more issues.
REQ-039 num_pkt=0 -> done=1 the cycle after start, no desc_valid; pkt_len=10 fixed -> desc_len=64.
REQ-040 abort asserted while desc_valid=1 and desc_ready=0 -> descriptor held until ready, then no more; DRAIN until completions match; aborted=1, done=1.
REQ-041 pkt_done in IDLE -> cpl_err=1, cpl_cnt unchanged; rst_n low mid-ISSUE -> all outputs 0 immediately.

Source files
------------

// File: rtl/hssi_tg_pkt_sched.sv
// hssi_tg_pkt_sched: packet descriptor scheduler for the HSSI traffic generator.
// A run starts with a start pulse and issues num_pkt descriptors (length,
// pattern, sequence number) to a packet generator. No more than MAX_OUT
// descriptors may be outstanding without a matching pkt_done. The run can be
// cut short by abort. A 16-bit LFSR supplies random packet lengths.
//
// Descriptor handshake: desc_valid/desc_ready use strict valid/ready rules.
// A transfer happens on a rising clk edge where desc_valid && desc_ready are
// both high. Once desc_valid is raised, desc_valid and all desc_* fields stay
// constant until that transfer. desc_valid never depends on desc_ready.
// While desc_valid is low, the desc_* fields are driven to zero.
module hssi_tg_pkt_sched #(
  parameter int CNT_W   = 32,
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = 64,
  parameter int MAX_OUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pkt,
  input  logic             len_type,
  input  logic             data_pattern,
  input  logic [LEN_W-1:0] pkt_len,
  output logic             desc_valid,
  input  logic             desc_ready,
  output logic [LEN_W-1:0] desc_len,
  output logic             desc_pattern,
  output logic [CNT_W-1:0] desc_seq,
  input  logic             pkt_done,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cpl_err,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] cpl_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  // Registered state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             len_type_q, len_type_d;
  logic             pattern_q, pattern_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] cpl_q, cpl_d;
  logic             aborted_q, aborted_d;
  logic             cpl_err_q, cpl_err_d;
  logic             abort_pend_q, abort_pend_d;

  // Derived combinational signals
  logic [CNT_W-1:0] outstanding;
  logic             slot_free;
  logic             offer;
  logic             hs;
  logic             start_ok;
  logic             abort_eff;
  logic [CNT_W-1:0] sent_inc;
  logic [CNT_W-1:0] cpl_inc;
  logic [15:0]      lfsr_next;
  logic [LEN_W-1:0] len_sel;

  // Saturating increment: counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE_C;
  endfunction

  // Flow-control and length datapath shared by the FSM and the outputs.
  always_comb begin
    outstanding = sent_q - cpl_q;
    slot_free   = (outstanding < MAX_OUT_C);
    offer       = (state_q == ST_ISSUE) && slot_free;
    hs          = offer && desc_ready;
    start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    abort_eff   = abort || abort_pend_q;
    sent_inc    = sat_inc(sent_q);
    cpl_inc     = sat_inc(cpl_q);
    // Fibonacci LFSR, taps 16,14,13,11, shifted left with feedback into bit 0.
    lfsr_next   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (len_type_q) begin
      len_sel = MIN_LEN_C + LEN_W'(lfsr_q[10:0]);
    end else if (pkt_len_q < MIN_LEN_C) begin
      len_sel = MIN_LEN_C;
    end else begin
      len_sel = pkt_len_q;
    end
  end

  // Next-state and register-update logic for the run FSM and its counters.
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    len_type_d   = len_type_q;
    pattern_d    = pattern_q;
    pkt_len_d    = pkt_len_q;
    lfsr_d       = lfsr_q;
    sent_d       = sent_q;
    cpl_d        = cpl_q;
    aborted_d    = aborted_q;
    cpl_err_d    = cpl_err_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_d        = num_pkt;
          len_type_d   = len_type;
          pattern_d    = data_pattern;
          pkt_len_d    = pkt_len;
          lfsr_d       = LFSR_SEED;
          sent_d       = '0;
          cpl_d        = '0;
          aborted_d    = 1'b0;
          cpl_err_d    = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = (num_pkt != '0) ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (hs) begin
          sent_d = sent_inc;
          lfsr_d = lfsr_next;
        end
        // An abort can only act once nothing is on offer, or together with
        // the transfer of the descriptor on offer. Until then it is held
        // pending, so a one-cycle abort pulse is not lost.
        if (abort_eff && (!offer || hs)) begin
          state_d      = ST_DRAIN;
          aborted_d    = 1'b1;
          abort_pend_d = 1'b0;
        end else if (hs && (sent_inc == num_q)) begin
          state_d = ST_DRAIN;
        end else if (abort_eff) begin
          abort_pend_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (outstanding == '0) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A completion with nothing outstanding is a protocol error. The
    // counters are cleared by an accepted start, which takes priority.
    if (!start_ok && pkt_done) begin
      if (outstanding != '0) begin
        cpl_d = cpl_inc;
      end else begin
        cpl_err_d = 1'b1;
      end
    end
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      num_q        <= '0;
      len_type_q   <= 1'b0;
      pattern_q    <= 1'b0;
      pkt_len_q    <= '0;
      lfsr_q       <= LFSR_SEED;
      sent_q       <= '0;
      cpl_q        <= '0;
      aborted_q    <= 1'b0;
      cpl_err_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      len_type_q   <= len_type_d;
      pattern_q    <= pattern_d;
      pkt_len_q    <= pkt_len_d;
      lfsr_q       <= lfsr_d;
      sent_q       <= sent_d;
      cpl_q        <= cpl_d;
      aborted_q    <= aborted_d;
      cpl_err_q    <= cpl_err_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Output drive: descriptor fields come only from registers, so they hold
  // steady while desc_valid waits for desc_ready.
  always_comb begin
    desc_valid   = offer;
    desc_len     = offer ? len_sel : '0;
    desc_pattern = offer & pattern_q;
    desc_seq     = offer ? sent_q : '0;
    busy         = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    done         = (state_q == ST_DONE);
    aborted      = aborted_q;
    cpl_err      = cpl_err_q;
    sent_cnt     = sent_q;
    cpl_cnt      = cpl_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_hssi_tg_pkt_sched.sv
// Bench for hssi_tg_pkt_sched.
// A run-level reference model tracks the run phase, the issued and completed
// counts, and the error and abort flags. The expected length of packet k is
// computed from scratch by stepping the LFSR k times from the seed. A compare
// process checks every cycle. Directed tests add literal expectations.
module tb_hssi_tg_pkt_sched;

  localparam int          CNT_W   = 32;
  localparam int          LEN_W   = 16;
  localparam int unsigned MAX_OUT = 8;

  // Clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic             start        = 1'b0;
  logic             abort        = 1'b0;
  logic [CNT_W-1:0] num_pkt      = '0;
  logic             len_type     = 1'b0;
  logic             data_pattern = 1'b0;
  logic [LEN_W-1:0] pkt_len      = '0;
  logic             desc_valid;
  logic             desc_ready   = 1'b0;
  logic [LEN_W-1:0] desc_len;
  logic             desc_pattern;
  logic [CNT_W-1:0] desc_seq;
  logic             pkt_done;
  logic             busy, done, aborted, cpl_err;
  logic [CNT_W-1:0] sent_cnt, cpl_cnt;
  logic [1:0]       dbg_state;

  logic       man_done  = 1'b0;
  logic       auto_done = 1'b0;
  logic       auto_en   = 1'b0;
  logic [3:0] cpl_pipe  = '0;
  assign pkt_done = man_done | auto_done;

  hssi_tg_pkt_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_pkt(num_pkt), .len_type(len_type), .data_pattern(data_pattern),
    .pkt_len(pkt_len), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_len(desc_len), .desc_pattern(desc_pattern), .desc_seq(desc_seq),
    .pkt_done(pkt_done), .busy(busy), .done(done), .aborted(aborted),
    .cpl_err(cpl_err), .sent_cnt(sent_cnt), .cpl_cnt(cpl_cnt),
    .dbg_state(dbg_state)
  );

  // Scoreboard counters
  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  localparam int P_IDLE = 0, P_ISSUE = 1, P_DRAIN = 2, P_DONE = 3;
  int          m_phase   = P_IDLE;
  int unsigned m_sent    = 0;
  int unsigned m_cpl     = 0;
  int unsigned m_num     = 0;
  int unsigned m_fixlen  = 0;
  bit          m_rand    = 1'b0;
  bit          m_pat     = 1'b0;
  bit          m_aborted = 1'b0;
  bit          m_err     = 1'b0;
  bit          m_pend    = 1'b0;
  bit          mo_offer, mo_hs;
  int unsigned mo_out;

  function automatic bit m_offer();
    return (m_phase == P_ISSUE) && ((m_sent - m_cpl) < MAX_OUT);
  endfunction

  // Length of packet k of the current run.
  function automatic int unsigned exp_len(input int unsigned k);
    logic [15:0] l;
    l = 16'hACE1;
    if (!m_rand) return (m_fixlen < 64) ? 64 : m_fixlen;
    for (int unsigned i = 0; i < k; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return 64 + 32'(l[10:0]);
  endfunction

  // Model update: once per rising edge from the inputs, or at reset.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = P_IDLE; m_sent = 0; m_cpl = 0; m_num = 0; m_fixlen = 0;
      m_rand = 0; m_pat = 0; m_aborted = 0; m_err = 0; m_pend = 0;
    end else begin
      mo_offer = m_offer();
      mo_hs    = mo_offer && desc_ready;
      mo_out   = m_sent - m_cpl;
      if ((m_phase == P_IDLE || m_phase == P_DONE) && start) begin
        m_num = num_pkt; m_rand = len_type; m_pat = data_pattern;
        m_fixlen = 32'(pkt_len); m_sent = 0; m_cpl = 0;
        m_aborted = 0; m_err = 0; m_pend = 0;
        m_phase = (num_pkt != 0) ? P_ISSUE : P_DONE;
      end else begin
        if (pkt_done) begin
          if (mo_out > 0) m_cpl++;
          else m_err = 1'b1;
        end
        if (m_phase == P_ISSUE) begin
          if (mo_hs) m_sent++;
          if ((abort || m_pend) && (!mo_offer || mo_hs)) begin
            m_phase = P_DRAIN; m_aborted = 1'b1; m_pend = 1'b0;
          end else if (m_sent == m_num) begin
            m_phase = P_DRAIN;
          end else if (abort) begin
            m_pend = 1'b1;
          end
        end else if (m_phase == P_DRAIN && mo_out == 0) begin
          m_phase = P_DONE;
        end
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("desc_valid", 32'(desc_valid), 32'(m_offer()));
      chk("busy", 32'(busy), 32'(m_phase == P_ISSUE || m_phase == P_DRAIN));
      chk("done", 32'(done), 32'(m_phase == P_DONE));
      chk("aborted", 32'(aborted), 32'(m_aborted));
      chk("cpl_err", 32'(cpl_err), 32'(m_err));
      chk("sent_cnt", sent_cnt, m_sent);
      chk("cpl_cnt", cpl_cnt, m_cpl);
      if (m_offer()) begin
        chk("desc_len", 32'(desc_len), exp_len(m_sent));
        chk("desc_seq", desc_seq, m_sent);
        chk("desc_pattern", 32'(desc_pattern), 32'(m_pat));
        if (m_rand) chk("len_range", 32'(desc_len >= 16'd64 && desc_len <= 16'd2111), 32'd1);
      end
    end
  end

  // Completion responder: pkt_done pulses a few cycles after each handshake.
  int hs_count = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cpl_pipe  = '0;
      auto_done = 1'b0;
    end else begin
      if (desc_valid && desc_ready) hs_count++;
      cpl_pipe  = {cpl_pipe[2:0], desc_valid & desc_ready & auto_en};
      auto_done = cpl_pipe[3];
    end
  end

  // Driver tasks
  task automatic drive_cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int unsigned n, input bit lt, input bit pat, input int unsigned len);
    @(posedge clk); #1;
    num_pkt = n; len_type = lt; data_pattern = pat; pkt_len = LEN_W'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; man_done = 1'b1;
    @(posedge clk); #1; man_done = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  int base;
  int iter;

  initial begin
    // Reset and quiescent state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(desc_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sent", sent_cnt, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk_en = 1'b1;

    // T1: 32 fixed-length packets of 0x42 bytes, completions after a delay
    desc_ready = 1'b1; auto_en = 1'b1;
    base = hs_count;
    pulse_start(32'h20, 1'b0, 1'b0, 16'h42);
    @(negedge clk);
    chk("t1_first_valid", 32'(desc_valid), 32'd1);
    chk("t1_first_len", 32'(desc_len), 32'd66);
    chk("t1_first_seq", desc_seq, 32'd0);
    wait_done("t1_done", 200);
    chk("t1_hs", 32'(hs_count - base), 32'd32);
    chk("t1_sent", sent_cnt, 32'd32);
    chk("t1_cpl", cpl_cnt, 32'd32);

    // T2: four random-length packets
    pulse_start(4, 1'b1, 1'b1, 0);
    @(negedge clk);
    chk("t2_first_len", 32'(desc_len), 32'd1313);
    chk("t2_pattern", 32'(desc_pattern), 32'd1);
    wait_done("t2_done", 100);
    chk("t2_sent", sent_cnt, 32'd4);

    // T3: outstanding limit with no completions
    auto_en = 1'b0;
    base = hs_count;
    pulse_start(20, 1'b0, 1'b0, 100);
    repeat (15) @(negedge clk);
    chk("t3_hs_cap", 32'(hs_count - base), 32'd8);
    chk("t3_valid_low", 32'(desc_valid), 32'd0);
    pulse_done();
    repeat (4) @(negedge clk);
    chk("t3_hs_one_more", 32'(hs_count - base), 32'd9);
    chk("t3_valid_low2", 32'(desc_valid), 32'd0);
    iter = 0;
    while (!done && iter < 40) begin
      pulse_done();
      drive_cycle();
      iter++;
    end
    @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_sent", sent_cnt, 32'd20);
    chk("t3_cpl", cpl_cnt, 32'd20);
    chk("t3_err", 32'(cpl_err), 32'd0);

    // T4: zero-packet run, then a short run below the minimum length
    pulse_start(0, 1'b0, 1'b0, 100);
    @(negedge clk);
    chk("t4_done_now", 32'(done), 32'd1);
    chk("t4_no_valid", 32'(desc_valid), 32'd0);
    auto_en = 1'b1;
    pulse_start(2, 1'b0, 1'b0, 10);
    @(negedge clk);
    chk("t4_min_len", 32'(desc_len), 32'd64);
    wait_done("t4_done", 50);

    // T5: abort while a descriptor waits for ready
    desc_ready = 1'b0;
    base = hs_count;
    pulse_start(10, 1'b0, 1'b0, 200);
    repeat (3) @(negedge clk);
    pulse_abort();
    repeat (3) @(negedge clk);
    chk("t5_held_valid", 32'(desc_valid), 32'd1);
    chk("t5_held_len", 32'(desc_len), 32'd200);
    chk("t5_no_hs", 32'(hs_count - base), 32'd0);
    drive_cycle();
    desc_ready = 1'b1;
    wait_done("t5_done", 40);
    chk("t5_hs", 32'(hs_count - base), 32'd1);
    chk("t5_aborted", 32'(aborted), 32'd1);
    chk("t5_sent", sent_cnt, 32'd1);
    chk("t5_cpl", cpl_cnt, 32'd1);

    // T6: reset in the middle of a run, then a stray completion in IDLE
    auto_en = 1'b0; desc_ready = 1'b0;
    pulse_start(20, 1'b0, 1'b0, 100);
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(desc_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_sent", sent_cnt, 32'd0);
    chk("t6_rst_len", 32'(desc_len), 32'd0);
    chk("t6_rst_seq", desc_seq, 32'd0);
    drive_cycle();
    rst_n = 1'b1;
    desc_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_issue", 32'(desc_valid), 32'd0);
    chk("t6_idle_sent", sent_cnt, 32'd0);
    pulse_done();
    @(negedge clk);
    chk("t6_cpl_err", 32'(cpl_err), 32'd1);
    chk("t6_cpl_cnt", cpl_cnt, 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
